// File: rtl/frame_write_dma.sv
// Frame capture DMA: buffers a pixel stream in a show-ahead FIFO and writes each frame
// to memory as fixed-length Avalon-MM bursts, starting on the stream's start-of-frame word.
module frame_write_dma #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          FRAME_WORDS = 153600,
  parameter int          BURST_LEN   = 64,
  parameter int          FIFO_DEPTH  = 256
) (
  input  logic                        clk,
  input  logic                        rest_n,
  input  logic                        enable,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [31:0]                 in_data,
  output logic [31:0]                 avl_address,
  output logic [3:0]                  avl_byte_en,
  output logic                        avl_write,
  output logic                        avl_read,
  output logic [31:0]                 avl_write_data,
  output logic                        avl_begin_burst_transfer,
  output logic [7:0]                  avl_burst_count,
  output logic                        avl_resp_ready,
  input  logic                        avl_request_ready,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] FRAME_L = 32'(FRAME_WORDS);
  localparam logic [31:0] BURST_L = 32'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_WAIT, S_BURST} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [31:0] wcnt_q, wcnt_d, addr_q, addr_d, remain, n_beats;
  logic [7:0]  blen_q, blen_d, beats_q, beats_d;
  logic        first_q, first_d, stop_q, stop_d, ovf_q, ovf_d;
  logic        full, accept, push_en, push, drop, last_beat;
  logic [31:0] mem [FIFO_DEPTH];

  // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == DEPTH_L);
  assign accept    = (state_q == S_BURST) && avl_request_ready;
  assign push_en   = in_valid && (((state_q == S_SYNC) && in_sof) ||
                                  (state_q == S_WAIT) || (state_q == S_BURST));
  assign push      = push_en && (!full || accept);
  assign drop      = push_en && full && !accept;
  assign remain    = FRAME_L - wcnt_q;
  assign n_beats   = (remain < BURST_L) ? remain : BURST_L;
  assign last_beat = (beats_q == 8'd1);

  assign avl_write                = (state_q == S_BURST);
  assign avl_begin_burst_transfer = avl_write && first_q;
  assign avl_write_data           = avl_write ? mem[rd_ptr_q[AW-1:0]] : 32'd0;
  assign avl_address              = addr_q;
  assign avl_burst_count          = blen_q;
  assign avl_byte_en              = 4'hF;
  assign avl_read                 = 1'b0;
  assign avl_resp_ready           = 1'b1;
  assign overflow                 = ovf_q;
  assign fifo_level               = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= in_data;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, accept};
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    blen_d     = blen_q;
    beats_d    = beats_q;
    first_d    = first_q;
    stop_d     = stop_q;
    ovf_d      = ovf_q | drop;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        wcnt_d   = '0;
        ovf_d    = 1'b0;
        stop_d   = 1'b0;
        if (enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!enable) state_d = S_IDLE;
        else if (in_valid && in_sof) begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) state_d = S_IDLE;
        else if (32'(level) >= n_beats) begin
          addr_d  = BASE_ADDR + (wcnt_q << 2);
          blen_d  = n_beats[7:0];
          beats_d = n_beats[7:0];
          first_d = 1'b1;
          stop_d  = 1'b0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        // A disable is remembered so the burst always runs to its full length.
        if (!enable) stop_d = 1'b1;
        if (accept) begin
          wcnt_d  = wcnt_q + 32'd1;
          first_d = 1'b0;
          beats_d = beats_q - 8'd1;
          if (last_beat) begin
            if (wcnt_q + 32'd1 == FRAME_L) begin
              frame_done = 1'b1;
              state_d    = S_SYNC;
            end else begin
              state_d = S_WAIT;
            end
            if (stop_q || !enable) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      blen_q   <= '0;
      beats_q  <= '0;
      first_q  <= 1'b0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      blen_q   <= blen_d;
      beats_q  <= beats_d;
      first_q  <= first_d;
      stop_q   <= stop_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: doc/frame_write_dma.md
FRAME_WRITE_DMA -- requirements
Module: frame_write_dma

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0 of the frame buffer.
REQ-002 Parameter FRAME_WORDS, default 153600: number of 32-bit words per frame (640x480 RGB565).
REQ-003 Parameter BURST_LEN, default 64: maximum beats per write burst, range 1..255.
REQ-004 Parameter FIFO_DEPTH, default 256: FIFO capacity in words, a power of two, >= 2*BURST_LEN.
REQ-005 Port clk, input, 1: single clock; everything is synchronous to its rising edge.
REQ-006 Port rest_n, input, 1: asynchronous active-low reset.
REQ-007 Port enable, input, 1: capture enable.
REQ-008 Port in_valid, input, 1: pixel word valid; there is no backpressure to the source.
REQ-009 Port in_sof, input, 1: qualifies in_valid as the first word of a frame.
REQ-010 Port in_data, input, 32: pixel word.
REQ-011 Port avl_address, output, 32: burst start byte address.
REQ-012 Port avl_byte_en, output, 4: byte enables.
REQ-013 Port avl_write, output, 1: write request.
REQ-014 Port avl_read, output, 1: read request, tied 0.
REQ-015 Port avl_write_data, output, 32: write beat data.
REQ-016 Port avl_begin_burst_transfer, output, 1: marks the first beat of a burst.
REQ-017 Port avl_burst_count, output, 8: beats in the current burst.
REQ-018 Port avl_resp_ready, output, 1: tied 1.
REQ-019 Port avl_request_ready, input, 1: a beat is accepted when avl_write and avl_request_ready are both 1 on a clk edge.
REQ-020 Port frame_done, output, 1: one-cycle pulse when the last frame word is accepted.
REQ-021 Port overflow, output, 1: sticky flag set when a word is dropped.
REQ-022 Port fifo_level, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-023 Internal show-ahead FIFO: a push and a pop in the same cycle leave the level unchanged; the FIFO head drives avl_write_data.
REQ-024 FSM states are IDLE, SYNC, WAIT and BURST.
REQ-025 IDLE: FIFO flushed, word counter cleared, overflow cleared; enable=1 moves to SYNC.
REQ-026 SYNC: words without in_sof are discarded; in_valid&&in_sof pushes that word, clears the word counter and moves to WAIT.
REQ-027 WAIT: n = min(BURST_LEN, FRAME_WORDS - words_written); when fifo_level >= n, the FSM moves to BURST on the next edge with avl_write=1.
REQ-028 Issue latency from the WAIT condition becoming true to avl_write=1 is one cycle.
REQ-029 BURST: avl_address = BASE_ADDR + 4*words_written is latched at burst start and held constant for the whole burst.
REQ-030 BURST: avl_burst_count = n is held constant for the whole burst; avl_byte_en = 4'hF.
REQ-031 avl_begin_burst_transfer = 1 only on the first beat and is held until that beat is accepted.
REQ-032 Each accepted beat pops the FIFO and increments words_written.
REQ-033 avl_write stays 1 with stable data while avl_request_ready=0.
REQ-034 After n beats are accepted: if words_written == FRAME_WORDS, pulse frame_done in the same cycle as the last acceptance and go to SYNC; otherwise go to WAIT.
REQ-035 Inside WAIT/BURST, in_sof is ignored and the word is stored as data.
REQ-036 FIFO pushes are allowed in SYNC (sof word only), WAIT and BURST.
REQ-037 in_valid while the FIFO is full (with no simultaneous pop) drops the word and sets overflow until IDLE or reset.
REQ-038 enable=0 in SYNC/WAIT moves to IDLE next cycle.
REQ-039 enable=0 in BURST completes the remaining beats, then moves to IDLE; a burst is never truncated.
REQ-040 A final partial burst is issued with avl_burst_count = FRAME_WORDS mod BURST_LEN.

Reset
REQ-041 rest_n=0 asynchronously forces state IDLE and clears the FIFO pointers and word counter.
REQ-042 While rest_n=0: avl_write=0, avl_begin_burst_transfer=0, avl_address=0, avl_burst_count=0, avl_write_data=0, frame_done=0, overflow=0, fifo_level=0.
REQ-043 Reset asserted mid-burst abandons the burst immediately.

Verification (BURST_LEN=4, FRAME_WORDS=10, BASE_ADDR=32'h100, FIFO_DEPTH=16 unless noted)
REQ-044 Full frame: enable=1, 10 words 1..10 with in_sof on word 1, avl_request_ready=1 -> three bursts at 0x100/4, 0x110/4, 0x120/2 with data 1..10 in order, frame_done pulses once, FSM back in SYNC.
REQ-045 Pre-sof discard: 3 words without sof, then a sof frame -> the discarded words never appear on the bus; first beat data equals the sof word.
REQ-046 Backpressure: avl_request_ready toggling 1010 during a burst -> address, burst_count and write_data stable while not ready; begin_burst_transfer high until first acceptance; no beat lost or duplicated.
REQ-047 Overflow: avl_request_ready=0, 20 words pushed -> fifo_level saturates at 16, overflow=1 on word 17, held until enable=0.
REQ-048 Disable mid-burst: enable=0 after beat 1 of 4 -> beats 2..4 complete, then IDLE and fifo_level=0.
REQ-049 Reset mid-burst: rest_n=0 at beat 2 -> all outputs at reset values in the same cycle; after release with enable=1, the FSM waits for a new sof.
